// File: rtl/sipo_deser.sv
// sipo_deser: serial-in / parallel-out deserializer with a one-word output buffer.
// Frames start with sof qualified by bit_en and complete after N bits. The word is
// presented on dout/dvalid with a valid/ready handshake. A completed word that
// finds the buffer still occupied is dropped and raises the sticky ovr flag.
// Optional feature: define PARITY_CHK_EN to expect one even-parity bit after the
// N data bits. A word that fails the check is dropped and perr pulses for one cycle.
module sipo_deser #(
  parameter int unsigned N         = 8,
  parameter int unsigned LSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sin,
  input  logic         bit_en,
  input  logic         sof,
  output logic [N-1:0] dout,
  output logic         dvalid,
  input  logic         dready,
  output logic         ovr,
  input  logic         clr_ovr,
  output logic         perr
);

  localparam int unsigned CntW = $clog2(N + 1);

`ifdef PARITY_CHK_EN
  typedef enum logic [1:0] {StIdle, StShift, StPar} state_e;
`else
  typedef enum logic [0:0] {StIdle, StShift} state_e;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [N-1:0]    sreg_q, sreg_d;
  logic [N-1:0]    dout_q, dout_d;
  logic            dvalid_q, dvalid_d;
  logic            ovr_q, ovr_d;
  logic            ovr_set;
  logic [N-1:0]    shifted, first_word, word;
  logic            complete;
`ifdef PARITY_CHK_EN
  logic            perr_q, perr_d;
`endif

  // Where the incoming bit enters the shift register, for both bit orders.
  always_comb begin
    shifted    = sreg_q;
    first_word = '0;
    if (LSB_FIRST != 0) begin
      shifted         = {sin, sreg_q[N-1:1]};
      first_word[N-1] = sin;
    end else begin
      shifted       = {sreg_q[N-2:0], sin};
      first_word[0] = sin;
    end
  end

  // Frame FSM: collect bits, flag completion of a good word.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    sreg_d   = sreg_q;
    complete = 1'b0;
    word     = shifted;
`ifdef PARITY_CHK_EN
    perr_d   = 1'b0;
`endif
    if (bit_en) begin
      case (state_q)
        StIdle: begin
          if (sof) begin
            sreg_d  = first_word;
            count_d = CntW'(1);
            state_d = StShift;
          end
        end
        StShift: begin
          if (sof) begin
            // Restart: the partial word is silently abandoned.
            sreg_d  = first_word;
            count_d = CntW'(1);
          end else begin
            sreg_d = shifted;
            if (count_q == CntW'(N - 1)) begin
`ifdef PARITY_CHK_EN
              count_d = CntW'(N);
              state_d = StPar;
`else
              count_d  = '0;
              state_d  = StIdle;
              complete = 1'b1;
              word     = shifted;
`endif
            end else begin
              count_d = count_q + CntW'(1);
            end
          end
        end
`ifdef PARITY_CHK_EN
        StPar: begin
          if (sof) begin
            sreg_d  = first_word;
            count_d = CntW'(1);
            state_d = StShift;
          end else begin
            count_d = '0;
            state_d = StIdle;
            word    = sreg_q;
            if (^{sreg_q, sin} == 1'b0) begin
              complete = 1'b1;
            end else begin
              perr_d = 1'b1;
            end
          end
        end
`endif
        default: state_d = StIdle;
      endcase
    end
  end

  // Output buffer handshake and sticky overrun flag (set beats clear).
  always_comb begin
    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    ovr_set  = 1'b0;
    if (complete) begin
      if (!dvalid_q || dready) begin
        dout_d   = word;
        dvalid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end else if (dvalid_q && dready) begin
      dvalid_d = 1'b0;
    end
    if (ovr_set) begin
      ovr_d = 1'b1;
    end else if (clr_ovr) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  // State registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      count_q  <= '0;
      sreg_q   <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      sreg_q   <= sreg_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ovr_q    <= ovr_d;
    end
  end

`ifdef PARITY_CHK_EN
  // Parity error pulse, one cycle per failed frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_d;
    end
  end
  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign ovr    = ovr_q;

endmodule
